// File: rtl/alu_result_display_pkg.sv
// ============================================================================
// Module : alu_result_display_pkg
// Brief  : Shared state encoding and 7-segment constants for the result display
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_result_display_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        FREE = 2'd2
    } state_t;

    // Segments g..a on bits 6..0, indexed by nibble value
    localparam logic [15:0][6:0] c_seg_table = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [6:0] c_seg_e     = 7'h79;
    localparam logic [6:0] c_seg_r     = 7'h50;
    localparam logic [6:0] c_seg_blank = 7'h00;

endpackage

`default_nettype wire

// File: rtl/alu_result_display_hex7seg.sv
// ============================================================================
// Module : hex7seg
// Brief  : Combinational hex nibble to active-high 7-segment decode
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hex7seg
    import alu_result_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    assign segments = c_seg_table[nibble];

endmodule

`default_nettype wire

// File: rtl/alu_result_display.sv
// ============================================================================
// Module : alu_result_display
// Brief  : Captures an ALU result and scans it across eight 7-segment digits
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_result_display
    import alu_result_display_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int HOLD_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        result_valid,
    output logic        result_ready,
    input  logic [31:0] result,
    input  logic        error,
    input  logic        divZero,
    output logic [6:0]  display,
    output logic [7:0]  digit_en,
    output logic        shown_err
);

    localparam int PRE_W  = $clog2(SCAN_DIV);
    localparam int HOLD_W = $clog2(HOLD_SCANS + 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [PRE_W-1:0]    r_presc;
    logic [2:0]          r_idx;
    logic [HOLD_W-1:0]   r_hold;
    logic [31:0]         r_result;
    logic                r_err;
    logic                r_dz;

    logic                w_transfer;
    logic                w_tick;
    logic                w_wrap;
    logic                w_hold_done;
    logic [3:0]          w_nibble;
    logic [6:0]          w_hex_seg;
    logic [6:0]          w_display;
    logic [7:0]          w_digit_en;

    assign w_transfer  = result_valid & result_ready;
    assign w_tick      = (r_presc == PRE_W'(SCAN_DIV - 1));
    assign w_wrap      = w_tick & (r_idx == 3'd7);
    assign w_hold_done = w_wrap & (r_hold == HOLD_W'(HOLD_SCANS - 1));

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (w_transfer)  w_next_state = SHOW;
            SHOW:    if (w_hold_done) w_next_state = FREE;
            FREE:    if (w_transfer)  w_next_state = SHOW;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_presc  <= '0;
            r_idx    <= '0;
            r_hold   <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_transfer) begin
                r_result <= result;
                r_err    <= error;
                r_dz     <= divZero;
                r_presc  <= '0;
                r_idx    <= '0;
                r_hold   <= '0;
            end else if (r_state != IDLE) begin
                r_presc <= w_tick ? '0 : r_presc + PRE_W'(1);
                if (w_tick) begin
                    r_idx <= r_idx + 3'd1;
                end
                // Holdoff only advances while a fresh value is being protected
                if (w_wrap && r_state == SHOW) begin
                    r_hold <= r_hold + HOLD_W'(1);
                end
            end
        end
    end

    assign w_nibble = r_result[{r_idx, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .nibble   (w_nibble),
        .segments (w_hex_seg)
    );

    always_comb begin
        w_display  = c_seg_blank;
        w_digit_en = '0;
        if (r_state != IDLE) begin
            w_digit_en = 8'b1 << r_idx;
            if (r_err || r_dz) begin
                // "E" then "r" (divide by zero) or "0" (overflow), rest blank
                unique case (r_idx)
                    3'd0:    w_display = c_seg_e;
                    3'd1:    w_display = r_dz ? c_seg_r : c_seg_table[0];
                    default: w_display = c_seg_blank;
                endcase
            end else begin
                w_display = w_hex_seg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            display      <= c_seg_blank;
            digit_en     <= '0;
            shown_err    <= 1'b0;
            result_ready <= 1'b1;
        end else begin
            display      <= w_display;
            digit_en     <= w_digit_en;
            shown_err    <= (r_state != IDLE) & (r_err | r_dz);
            result_ready <= (w_next_state != SHOW);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_result_display.sv
// ============================================================================
// Module : tb_alu_result_display
// Brief  : Directed self-checking bench for alu_result_display
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_result_display;

    localparam int SCAN_DIV   = 4;
    localparam int HOLD_SCANS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result;
    logic        error;
    logic        divZero;
    logic [6:0]  display;
    logic [7:0]  digit_en;
    logic        shown_err;

    int n_vec = 0;
    int n_err = 0;

    logic [6:0] hex_seg [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    alu_result_display #(
        .SCAN_DIV   (SCAN_DIV),
        .HOLD_SCANS (HOLD_SCANS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .error        (error),
        .divZero      (divZero),
        .display      (display),
        .digit_en     (digit_en),
        .shown_err    (shown_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 200; i++) begin
            if (result_ready === 1'b1) break;
            tick();
        end
        n_vec++;
        if (result_ready !== 1'b1) begin
            n_err++;
            $display("FAIL wait_ready: result_ready=%b after 200 cycles, want 1", result_ready);
        end
    endtask

    task automatic transfer(input logic [31:0] val, input logic e, input logic dz);
        wait_ready();
        result       = val;
        error        = e;
        divZero      = dz;
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        error        = 1'b0;
        divZero      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; result_valid = 1'b0; result = '0; error = 1'b0; divZero = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (result_ready !== 1'b1 || display !== 7'h00 || digit_en !== 8'h00 || shown_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset: ready=%b display=%h digit_en=%h err=%b, want 1 00 00 0",
                     result_ready, display, digit_en, shown_err);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_vec++;
            if (result_ready !== 1'b1 || display !== 7'h00 || digit_en !== 8'h00) begin
                n_err++;
                $display("FAIL idle c=%0d: ready=%b display=%h digit_en=%h, want 1 00 00",
                         i, result_ready, display, digit_en);
            end
        end
    endtask

    task automatic test_scan_digits();
        logic [31:0] v = 32'h0000_0007;
        int d;
        logic [7:0] exp_en;
        logic [6:0] exp_disp;
        transfer(v, 1'b0, 1'b0);
        n_vec++;
        if (result_ready !== 1'b0) begin
            n_err++;
            $display("FAIL scan ready-drop: result_ready=%b, want 0", result_ready);
        end
        for (int k = 1; k <= 33; k++) begin
            tick();
            d        = ((k - 1) / 4) % 8;
            exp_en   = 8'b1 << d;
            exp_disp = hex_seg[int'((v >> (4 * d)) & 32'hF)];
            n_vec++;
            if (digit_en !== exp_en || display !== exp_disp || shown_err !== 1'b0) begin
                n_err++;
                $display("FAIL scan k=%0d: digit_en=%h display=%h err=%b, want %h %h 0",
                         k, digit_en, display, shown_err, exp_en, exp_disp);
            end
        end
    endtask

    task automatic test_holdoff();
        logic [31:0] v = 32'hFFFF_FFFA;
        int d;
        logic exp_rdy;
        logic [7:0] exp_en;
        logic [6:0] exp_disp;
        transfer(v, 1'b0, 1'b0);
        for (int k = 1; k <= 70; k++) begin
            tick();
            exp_rdy  = (k >= 64);
            d        = ((k - 1) / 4) % 8;
            exp_en   = 8'b1 << d;
            exp_disp = (d == 0) ? 7'h77 : 7'h71;
            n_vec++;
            if (result_ready !== exp_rdy || digit_en !== exp_en || display !== exp_disp) begin
                n_err++;
                $display("FAIL holdoff k=%0d: ready=%b digit_en=%h display=%h, want %b %h %h",
                         k, result_ready, digit_en, display, exp_rdy, exp_en, exp_disp);
            end
        end
    endtask

    task automatic test_error();
        int d;
        logic [7:0] exp_en;
        logic [6:0] exp_disp;
        transfer(32'hFFFF_FFFF, 1'b0, 1'b1);
        for (int k = 1; k <= 32; k++) begin
            tick();
            d        = ((k - 1) / 4) % 8;
            exp_en   = 8'b1 << d;
            exp_disp = (d == 0) ? 7'h79 : (d == 1) ? 7'h50 : 7'h00;
            n_vec++;
            if (digit_en !== exp_en || display !== exp_disp || shown_err !== 1'b1) begin
                n_err++;
                $display("FAIL divzero k=%0d: digit_en=%h display=%h err=%b, want %h %h 1",
                         k, digit_en, display, shown_err, exp_en, exp_disp);
            end
        end
        transfer(32'h8000_0000, 1'b1, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            d        = (k - 1) / 4;
            exp_en   = 8'b1 << d;
            exp_disp = (d == 0) ? 7'h79 : 7'h3F;
            n_vec++;
            if (digit_en !== exp_en || display !== exp_disp || shown_err !== 1'b1) begin
                n_err++;
                $display("FAIL overflow k=%0d: digit_en=%h display=%h err=%b, want %h %h 1",
                         k, digit_en, display, shown_err, exp_en, exp_disp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a = 32'h1234_5678;
        logic [31:0] b = 32'hC0DE_0409;
        int d;
        logic exp_rdy;
        logic [7:0] exp_en;
        logic [6:0] exp_disp;
        transfer(a, 1'b0, 1'b0);
        result_valid = 1'b1;
        result       = 32'hC0DE_0009;
        for (int k = 1; k <= 64; k++) begin
            tick();
            exp_rdy  = (k >= 64);
            d        = ((k - 1) / 4) % 8;
            exp_en   = 8'b1 << d;
            exp_disp = hex_seg[int'((a >> (4 * d)) & 32'hF)];
            n_vec++;
            if (result_ready !== exp_rdy || digit_en !== exp_en || display !== exp_disp || shown_err !== 1'b0) begin
                n_err++;
                $display("FAIL hold k=%0d: ready=%b digit_en=%h display=%h err=%b, want %b %h %h 0",
                         k, result_ready, digit_en, display, shown_err, exp_rdy, exp_en, exp_disp);
            end
            result = 32'hC0DE_0009 | (32'(k) << 4);
        end
        for (int k = 65; k <= 81; k++) begin
            tick();
            n_vec++;
            if (result_ready !== 1'b0) begin
                n_err++;
                $display("FAIL single-transfer k=%0d: result_ready=%b, want 0", k, result_ready);
            end
            if (k >= 66) begin
                d        = (k - 66) / 4;
                exp_en   = 8'b1 << d;
                exp_disp = hex_seg[int'((b >> (4 * d)) & 32'hF)];
                n_vec++;
                if (digit_en !== exp_en || display !== exp_disp) begin
                    n_err++;
                    $display("FAIL free-capture k=%0d: digit_en=%h display=%h, want %h %h",
                             k, digit_en, display, exp_en, exp_disp);
                end
            end
            result = 32'hC0DE_0009 | (32'(k) << 4);
        end
        result_valid = 1'b0;
    endtask

    task automatic test_reset_midscan();
        logic [31:0] v = 32'hABCD_EF01;
        int d;
        logic [7:0] exp_en;
        logic [6:0] exp_disp;
        wait_ready();
        repeat (5) tick();
        rst          = 1'b1;
        result_valid = 1'b1;
        result       = 32'h0000_0005;
        tick();
        rst          = 1'b0;
        result_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (result_ready !== 1'b1 || display !== 7'h00 || digit_en !== 8'h00 || shown_err !== 1'b0) begin
                n_err++;
                $display("FAIL reset-midscan c=%0d: ready=%b display=%h digit_en=%h err=%b, want 1 00 00 0",
                         i, result_ready, display, digit_en, shown_err);
            end
            tick();
        end
        transfer(v, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            d        = (k - 1) / 4;
            exp_en   = 8'b1 << d;
            exp_disp = hex_seg[int'((v >> (4 * d)) & 32'hF)];
            n_vec++;
            if (digit_en !== exp_en || display !== exp_disp) begin
                n_err++;
                $display("FAIL post-reset k=%0d: digit_en=%h display=%h, want %h %h",
                         k, digit_en, display, exp_en, exp_disp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_digits();
        test_holdoff();
        test_error();
        test_back_to_back();
        test_reset_midscan();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
